// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with exception PC and a circular
// return-address stack for call/return prediction.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hold pc (redirect/call/ret ignored while set)
//   redirect_valid take redirect_pc on the next edge
//   redirect_pc    redirect target
//   call           with redirect_valid: push pc+INC onto the RAS
//   ret            without redirect_valid: pop the RAS and jump to its top
//   exc_valid      jump to EXC_VEC and capture the current pc in epc
//   eret           jump back to epc
//   pc             current fetch PC (registered)
//   epc            saved exception PC (registered)
//   ras_count      number of valid RAS entries, 0..RAS_DEPTH
//   ras_underflow  sticky flag: ret seen while the RAS was empty
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4,
    localparam int unsigned     CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic             ret,
    input  logic             exc_valid,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic [CW-1:0]    ras_count,
    output logic             ras_underflow
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    // RAS storage; ptr always points at the next slot to be written.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_next;
    logic             push;
    logic             pop;
    logic             underflow_set;

    // Sequential successor; wraps modulo 2^WIDTH by construction.
    assign pc_seq = pc + WIDTH'(INC);

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));

    // Explicit wrap so non-power-of-two depths stay within range.
    assign ptr_inc = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);

    assign ras_top = ras_mem[ptr_dec];

    // Next-PC selection, highest priority first.
    always_comb begin
        pc_next       = pc;
        epc_next      = epc;
        push          = 1'b0;
        pop           = 1'b0;
        underflow_set = 1'b0;
        if (exc_valid) begin
            pc_next  = EXC_VEC;
            epc_next = pc;
        end else if (eret) begin
            pc_next = epc;
        end else if (stall) begin
            // Upstream re-presents any redirect/call/ret after the stall.
            pc_next = pc;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
            push    = call;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_next = ras_top;
                pop     = 1'b1;
            end else begin
                pc_next       = pc_seq;
                underflow_set = 1'b1;
            end
        end else begin
            pc_next = pc_seq;
        end
    end

    // Architectural state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VEC;
            epc           <= '0;
            ptr           <= '0;
            ras_count     <= '0;
            ras_underflow <= 1'b0;
        end else begin
            pc  <= pc_next;
            epc <= epc_next;
            if (push) begin
                ptr <= ptr_inc;
                // A push into a full stack overwrites the oldest entry.
                if (!ras_full) begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (pop) begin
                ptr       <= ptr_dec;
                ras_count <= ras_count - CW'(1);
            end
            if (underflow_set) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    // RAS contents need no reset; only count and pointer define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[ptr] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a
// queue-based reference model; a second 8-bit instance covers wrap.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        call;
    logic        ret;
    logic        exc_valid;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    logic       reset8;
    logic       redirect_valid8;
    logic [7:0] redirect_pc8;
    logic       zero8 = 1'b0;
    logic [7:0] pc8;
    logic [7:0] epc8;
    logic [2:0] ras_count8;
    logic       ras_underflow8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_uf;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .call(call), .ret(ret), .exc_valid(exc_valid), .eret(eret),
        .pc(pc), .epc(epc), .ras_count(ras_count),
        .ras_underflow(ras_underflow)
    );

    pc_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .stall(zero8),
        .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
        .call(zero8), .ret(zero8), .exc_valid(zero8), .eret(zero8),
        .pc(pc8), .epc(epc8), .ras_count(ras_count8),
        .ras_underflow(ras_underflow8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
        check({tag, ".uf"}, 32'(ras_underflow), 32'(m_uf));
    endtask

    task automatic model(input logic rs, st, rv, input logic [31:0] rp,
                         input logic cl, rt, ex, er);
        if (rs) begin
            m_pc = 32'h0;
            m_epc = 32'h0;
            m_uf = 1'b0;
            m_ras.delete();
        end else if (ex) begin
            m_epc = m_pc;
            m_pc = 32'h80;
        end else if (er) begin
            m_pc = m_epc;
        end else if (st) begin
            m_pc = m_pc;
        end else if (rv) begin
            if (cl) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            m_pc = rp;
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc = m_pc + 32'd4;
                m_uf = 1'b1;
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag, input logic rs, st, rv,
                        input logic [31:0] rp,
                        input logic cl, rt, ex, er);
        reset = rs;
        stall = st;
        redirect_valid = rv;
        redirect_pc = rp;
        call = cl;
        ret = rt;
        exc_valid = ex;
        eret = er;
        model(rs, st, rv, rp, cl, rt, ex, er);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        call = 1'b0;
        ret = 1'b0;
        exc_valid = 1'b0;
        eret = 1'b0;
        reset8 = 1'b1;
        redirect_valid8 = 1'b0;
        redirect_pc8 = '0;
        m_pc = '0;
        m_epc = '0;
        m_uf = 1'b0;
        @(negedge clk);

        // 8-bit instance: wrap from 0xFC while the main DUT sits in reset
        step("rst", 1, 0, 0, 32'h0, 0, 0, 0, 0);
        check("w8_rst", 32'(pc8), 32'h0);
        reset8 = 1'b0;
        redirect_valid8 = 1'b1;
        redirect_pc8 = 8'hFC;
        step("rst", 1, 0, 0, 32'h0, 0, 0, 0, 0);
        check("w8_fc", 32'(pc8), 32'hFC);
        redirect_valid8 = 1'b0;
        step("rst", 1, 0, 0, 32'h0, 0, 0, 0, 0);
        check("w8_wrap", 32'(pc8), 32'h00);

        // Reset value then sequential increment
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", 32'(ras_count), 32'h0);
        idle("idle1");
        idle("idle2");
        idle("idle3");
        check("idle_pc12", pc, 32'hC);

        // Single call/return
        step("to10", 0, 0, 1, 32'h10, 0, 0, 0, 0);
        step("call", 0, 0, 1, 32'h200, 1, 0, 0, 0);
        check("call_pc", pc, 32'h200);
        check("call_cnt", 32'(ras_count), 32'h1);
        step("ret", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("ret_pc", pc, 32'h14);

        // Overflow: five calls into a four-entry stack
        step("to0", 0, 0, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step("calls", 0, 0, 1, 32'(i) << 8, 1, 0, 0, 0);
        check("full_cnt", 32'(ras_count), 32'h4);
        step("r1", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("r1_pc", pc, 32'h404);
        step("r2", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("r2_pc", pc, 32'h304);
        step("r3", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("r3_pc", pc, 32'h204);
        step("r4", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("r4_pc", pc, 32'h104);
        step("r5", 0, 0, 0, 32'h0, 0, 1, 0, 0);
        check("r5_pc", pc, 32'h108);
        check("r5_uf", 32'(ras_underflow), 32'h1);

        // Exception overrides stall, then return
        step("to40", 0, 0, 1, 32'h40, 0, 0, 0, 0);
        step("exc", 0, 1, 0, 32'h0, 0, 0, 1, 0);
        check("exc_pc", pc, 32'h80);
        check("exc_epc", epc, 32'h40);
        step("eret", 0, 0, 0, 32'h0, 0, 0, 0, 1);
        check("eret_pc", pc, 32'h40);

        // Stall holds pc and swallows the redirect
        step("st1", 0, 1, 1, 32'h300, 0, 0, 0, 0);
        step("st2", 0, 1, 1, 32'h300, 0, 0, 0, 0);
        check("st_pc", pc, 32'h40);
        step("unst", 0, 0, 1, 32'h300, 0, 0, 0, 0);
        check("unst_pc", pc, 32'h300);

        // Reset mid-operation clears the RAS and the sticky flag
        step("c1", 0, 0, 1, 32'h500, 1, 0, 0, 0);
        step("c2", 0, 0, 1, 32'h600, 1, 0, 0, 0);
        step("c3", 0, 0, 1, 32'h700, 1, 0, 0, 0);
        check("mid_cnt", 32'(ras_count), 32'h3);
        step("midrst", 1, 0, 0, 32'h0, 0, 0, 0, 0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_cnt", 32'(ras_count), 32'h0);
        check("midrst_uf", 32'(ras_underflow), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step("rand",
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
